// File: rtl/sig_meas_pkg.sv
// Shared types and helpers for the sine period measurement path.
package sig_meas_pkg;

    typedef enum logic [1:0] {
        FIRST_LOW  = 2'd0,
        FIRST_HIGH = 2'd1,
        SEEK_LOW   = 2'd2,
        SEEK_HIGH  = 2'd3
    } meas_state_t;

    function automatic int unsigned mid_of(input int unsigned width);
        mid_of = 32'd1 << (width - 32'd1);
    endfunction

endpackage

// File: rtl/crossing_detect.sv
// Hysteresis comparator and crossing FSM; flags rising midscale crossings of din.
module crossing_detect
    import sig_meas_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HYST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    output logic             rise_x,
    output logic             first,
    output logic             seeking
);

    localparam logic [WIDTH-1:0] LO = WIDTH'(mid_of(WIDTH) - 32'(HYST));
    localparam logic [WIDTH-1:0] HI = WIDTH'(mid_of(WIDTH) + 32'(HYST));

    meas_state_t state_q;
    meas_state_t state_d;
    logic        below_s;
    logic        above_s;

    assign below_s = (din < LO);
    assign above_s = (din >= HI);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FIRST_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; samples inside the hysteresis band never move the FSM
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                FIRST_LOW:  if (below_s) state_d = FIRST_HIGH; else state_d = FIRST_LOW;
                FIRST_HIGH: if (above_s) state_d = SEEK_LOW;   else state_d = FIRST_HIGH;
                SEEK_LOW:   if (below_s) state_d = SEEK_HIGH;  else state_d = SEEK_LOW;
                SEEK_HIGH:  if (above_s) state_d = SEEK_LOW;   else state_d = SEEK_HIGH;
                default:    state_d = FIRST_LOW;
            endcase
            if (abort) begin
                state_d = FIRST_LOW;
            end else begin
                state_d = state_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Outputs decoded from the current state and the presented sample
    always_comb begin
        rise_x  = 1'b0;
        first   = 1'b0;
        seeking = 1'b0;
        case (state_q)
            FIRST_HIGH: begin
                rise_x = en & above_s;
                first  = 1'b1;
            end
            SEEK_LOW: begin
                seeking = 1'b1;
            end
            SEEK_HIGH: begin
                rise_x  = en & above_s;
                seeking = 1'b1;
            end
            default: begin
                rise_x = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sine_period_meter.sv
// Measures the period (in en-samples) between rising midscale crossings of a sample stream.
// Optional PERIOD_AVG_EN: report the mean of the last four raw periods.
module sine_period_meter
    import sig_meas_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 16,
    parameter int HYST       = 4,
    parameter int MAX_PERIOD = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);

    logic             rise_x_s;
    logic             first_s;
    logic             seeking_s;
    logic             timeout_hit_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] diff_s;
    logic             lock_ok_s;

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic             valid_q,    valid_d;
    logic             locked_q,   locked_d;
    logic             timeout_q,  timeout_d;
    logic [CNT_W-1:0] prev_q,     prev_d;
    logic             prev_vld_q, prev_vld_d;

`ifdef PERIOD_AVG_EN
    logic [2:0][CNT_W-1:0] hist_q, hist_d;
    logic [2:0]            navg_q, navg_d;
    logic [CNT_W+1:0]      sum_s;

    assign sum_s = {2'b00, cnt_inc_s} + {2'b00, hist_q[0]}
                 + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
`endif

    crossing_detect #(
        .WIDTH (WIDTH),
        .HYST  (HYST)
    ) u_xdet (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .abort   (timeout_hit_s),
        .rise_x  (rise_x_s),
        .first   (first_s),
        .seeking (seeking_s)
    );

    assign cnt_inc_s     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // A crossing on the boundary sample takes precedence over timeout
    assign timeout_hit_s = en & seeking_s & ~rise_x_s & (cnt_inc_s >= MAX_P);
    assign diff_s        = (cnt_inc_s >= prev_q) ? (cnt_inc_s - prev_q) : (prev_q - cnt_inc_s);
    assign lock_ok_s     = prev_vld_q & (diff_s <= {{(CNT_W-1){1'b0}}, 1'b1});

    // Counter, measurement, lock and timeout next-state
    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
`ifdef PERIOD_AVG_EN
        hist_d     = hist_q;
        navg_d     = navg_q;
`endif
        if (en) begin
            if (rise_x_s) begin
                cnt_d = {CNT_W{1'b0}};
                if (!first_s) begin
                    prev_d     = cnt_inc_s;
                    prev_vld_d = 1'b1;
                    locked_d   = lock_ok_s;
                    timeout_d  = 1'b0;
`ifdef PERIOD_AVG_EN
                    hist_d[0] = cnt_inc_s;
                    hist_d[1] = hist_q[0];
                    hist_d[2] = hist_q[1];
                    if (navg_q == 3'd3) begin
                        period_d = sum_s[CNT_W+1:2];
                        valid_d  = 1'b1;
                    end else begin
                        navg_d = navg_q + 3'd1;
                    end
`else
                    period_d = cnt_inc_s;
                    valid_d  = 1'b1;
`endif
                end else begin
                    prev_d = prev_q;
                end
            end else if (timeout_hit_s) begin
                cnt_d      = {CNT_W{1'b0}};
                timeout_d  = 1'b1;
                locked_d   = 1'b0;
                prev_vld_d = 1'b0;
`ifdef PERIOD_AVG_EN
                navg_d     = 3'd0;
`endif
            end else if (seeking_s) begin
                cnt_d = cnt_inc_s;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= {CNT_W{1'b0}};
            period_q   <= {CNT_W{1'b0}};
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            prev_q     <= {CNT_W{1'b0}};
            prev_vld_q <= 1'b0;
`ifdef PERIOD_AVG_EN
            hist_q     <= {(3*CNT_W){1'b0}};
            navg_q     <= 3'd0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
`ifdef PERIOD_AVG_EN
            hist_q     <= hist_d;
            navg_q     <= navg_d;
`endif
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_sine_period_meter.sv
// Directed self-checking bench for sine_period_meter (default build; PERIOD_AVG_EN runs the averaging case).
module tb_sine_period_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [7:0]  din = 8'd0;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    int          checks = 0;
    int          errors = 0;
    int          ph     = 0;
    int unsigned per_q[$];
    logic        lock_q[$];

    sine_period_meter dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .din          (din),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Log every reported period and the lock state that accompanied it
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            per_q.push_back(int'(period));
            lock_q.push_back(locked);
        end
    end

    function automatic logic [7:0] sine_val(input int p);
        real r;
        r = 127.5 + 127.0 * $sin(6.283185307179586 * p / 256.0);
        return 8'($rtoi(r));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] d);
        @(negedge clk);
        en  = e;
        din = d;
    endtask

    task automatic run_sine(input int incr, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, sine_val(ph));
            ph = (ph + incr) % 256;
        end
    endtask

    task automatic seg(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, d);
    endtask

    task automatic settle();
        drive(1'b0, 8'd0);
        drive(1'b0, 8'd0);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ph  = 0;
        per_q.delete();
        lock_q.delete();
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);

`ifdef PERIOD_AVG_EN
        // periods 64,64,66,66 -> one averaged report of 65
        seg(8'd100, 32); seg(8'd160, 32); seg(8'd100, 32); seg(8'd160, 32);
        seg(8'd100, 32); seg(8'd160, 32); seg(8'd100, 34); seg(8'd160, 32);
        seg(8'd100, 34); seg(8'd160, 32);
        settle();
        check("avg_count", per_q.size(), 1);
        check("avg_period", per_q[0], 65);
        check("avg_locked", lock_q[0], 1);
`else
        // incr=1 sine: crossings at samples 258, 514, 770
        run_sine(1, 780);
        settle();
        check("t1_count", per_q.size(), 2);
        check("t1_per0", per_q[0], 256);
        check("t1_per1", per_q[1], 256);
        check("t1_lock0", lock_q[0], 0);
        check("t1_lock1", lock_q[1], 1);
        check("t1_timeout", timeout, 0);

        // incr=4 then switch to incr=8 right after a crossing
        do_reset();
        run_sine(4, 194);
        settle();
        check("t2_count4", per_q.size(), 2);
        check("t2_per4", per_q[1], 64);
        check("t2_lock4", lock_q[1], 1);
        per_q.delete();
        lock_q.delete();
        run_sine(8, 100);
        settle();
        check("t2_count8", per_q.size(), 3);
        check("t2_per8a", per_q[0], 33);
        check("t2_per8b", per_q[1], 32);
        check("t2_per8c", per_q[2], 32);
        check("t2_lock8a", lock_q[0], 0);
        check("t2_lock8b", lock_q[1], 1);

        // square 100/160, 10 en-samples each, en=0 cycles carry hostile values
        do_reset();
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, ((i / 10) % 2 == 1) ? 8'd160 : 8'd100);
            drive(1'b0, ((i / 10) % 2 == 1) ? 8'd0 : 8'd255);
        end
        settle();
        check("t3_count", per_q.size(), 2);
        check("t3_per0", per_q[0], 20);
        check("t3_per1", per_q[1], 20);
        check("t3_lock1", lock_q[1], 1);

        // one crossing then in-band noise -> timeout on the 4095th sample
        do_reset();
        drive(1'b1, 8'd100);
        drive(1'b1, 8'd160);
        for (int i = 0; i < 4094; i++) drive(1'b1, 8'(126 + (i % 5)));
        settle();
        check("t4_no_timeout_yet", timeout, 0);
        drive(1'b1, 8'd128);
        settle();
        check("t4_timeout", timeout, 1);
        check("t4_count", per_q.size(), 0);
        check("t4_period", period, 0);
        ph = 0;
        run_sine(8, 34);
        settle();
        check("t4_timeout_held", timeout, 1);
        check("t4_count_first", per_q.size(), 0);
        run_sine(8, 32);
        settle();
        check("t4_timeout_clr", timeout, 0);
        check("t4_per", per_q[0], 32);
        check("t4_lock", locked, 0);

        // reset mid-period at incr=2
        do_reset();
        run_sine(2, 400);
        settle();
        check("t5_count_pre", per_q.size(), 2);
        check("t5_lock_pre", locked, 1);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        din = sine_val(ph);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("t5_rst_period", period, 0);
        check("t5_rst_locked", locked, 0);
        check("t5_rst_valid", period_valid, 0);
        per_q.delete();
        lock_q.delete();
        run_sine(2, 200);
        settle();
        check("t5_count_first", per_q.size(), 0);
        run_sine(2, 60);
        settle();
        check("t5_count", per_q.size(), 1);
        check("t5_per", per_q[0], 128);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
